// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//
// Time-multiplexed driver for a common-anode, DIGITS-wide seven-segment
// display. A prescaler sets how long each digit stays selected, a
// free-running PWM counter dims the display, and new data is
// double-buffered so that a frame never shows a mix of old and new digits.
//
// Parameters
//   DIGITS    number of multiplexed digits (1..8)
//   DIV       clock cycles each digit stays selected (2..2^20)
//   BRIGHT_W  width of the brightness control (1..8)
//
// Ports
//   i_clk                  sole clock, rising edge
//   i_reset                synchronous, active-high reset
//   i_Data                 hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   i_DP                   decimal point per digit, 1 = lit
//   i_Load                 strobe: capture i_Data/i_DP into the pending buffer
//   i_Blank_Zeros          suppress leading zeros (digit 0 is never blanked)
//   i_Brightness           duty level, 0 = dimmest, all ones = fully on
//   o_Chosen_Segment       digit selects, active-low, at most one low
//   o_SevenSegmentDisplay  {dp,g,f,e,d,c,b,a}, active-low
//   o_Frame_Done           one-cycle pulse after each frame wrap

module seven_segment_mux #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000,
  parameter int BRIGHT_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*DIGITS-1:0]   i_Data,
  input  logic [DIGITS-1:0]     i_DP,
  input  logic                  i_Load,
  input  logic                  i_Blank_Zeros,
  input  logic [BRIGHT_W-1:0]   i_Brightness,
  output logic [DIGITS-1:0]     o_Chosen_Segment,
  output logic [7:0]            o_SevenSegmentDisplay,
  output logic                  o_Frame_Done
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Segment pattern {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------
  // Timing: prescaler, digit index, PWM
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm;
  logic                tick;
  logic                frame_boundary;

  assign tick           = (cnt == CNT_LAST);
  assign frame_boundary = tick && (idx == IDX_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + BRIGHT_W'(1);
      if (tick) begin
        cnt <= '0;
        // With DIGITS=1, IDX_LAST is 0 so idx simply stays at 0.
        if (idx == IDX_LAST) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Double buffer: loads land in pending, active only changes at a frame
  // boundary. On a load coinciding with the boundary, active takes the
  // previous pending contents (if any) and the new load stays pending.
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_flag;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (frame_boundary && pend_flag) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
      if (i_Load) begin
        pend_data <= i_Data;
        pend_dp   <= i_DP;
      end
      pend_flag <= i_Load || (pend_flag && !frame_boundary);
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero detection: zero_from[k] is set when active nibbles
  // k..DIGITS-1 are all zero.
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] zero_from;

  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run          = run && (act_data[4*k +: 4] == 4'h0);
      zero_from[k] = run;
    end
  end

  // ---------------------------------------------------------------------
  // Current digit selection
  // ---------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blankable;

  always_comb begin
    cur_nib       = 4'h0;
    cur_dp        = 1'b0;
    cur_blankable = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib       = act_data[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_blankable = (k != 0) && zero_from[k];
      end
    end
  end

  logic              lit;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] sel_next;

  assign lit      = (pwm <= i_Brightness);
  assign seg_next = (i_Blank_Zeros && cur_blankable) ? 7'h7F : hex_to_seg(cur_nib);
  assign sel_next = lit ? ~(DIGITS'(1) << idx) : '1;

  // ---------------------------------------------------------------------
  // Registered outputs, one clock behind idx/pwm/active.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Chosen_Segment      <= '1;
      o_SevenSegmentDisplay <= 8'hFF;
      o_Frame_Done          <= 1'b0;
    end else begin
      o_Chosen_Segment      <= sel_next;
      o_SevenSegmentDisplay <= {~cur_dp, seg_next};
      o_Frame_Done          <= frame_boundary;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  localparam int DIGITS   = 4;
  localparam int DIV      = 4;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIV * DIGITS;

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic [4*DIGITS-1:0]   i_Data;
  logic [DIGITS-1:0]     i_DP;
  logic                  i_Load;
  logic                  i_Blank_Zeros;
  logic [BRIGHT_W-1:0]   i_Brightness;
  logic [DIGITS-1:0]     o_Chosen_Segment;
  logic [7:0]            o_SevenSegmentDisplay;
  logic                  o_Frame_Done;

  always #5 i_clk = ~i_clk;

  seven_segment_mux #(.DIGITS(DIGITS), .DIV(DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_Data                (i_Data),
    .i_DP                  (i_DP),
    .i_Load                (i_Load),
    .i_Blank_Zeros         (i_Blank_Zeros),
    .i_Brightness          (i_Brightness),
    .o_Chosen_Segment      (o_Chosen_Segment),
    .o_SevenSegmentDisplay (o_SevenSegmentDisplay),
    .o_Frame_Done          (o_Frame_Done)
  );

  typedef struct packed {
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
    logic              fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: display position is derived purely from the number
  // of clock edges since reset; buffers follow the load/frame rules.
  int unsigned       m_n;
  logic [15:0]       m_act, m_pend;
  logic [DIGITS-1:0] m_act_dp, m_pend_dp;
  logic              m_pf;

  always @(posedge i_clk) begin
    exp_t e;
    int   d;
    bit   bnd;
    logic [3:0] nib;
    logic [15:0] upper;
    if (i_reset) begin
      e.sel = '1;
      e.seg = 8'hFF;
      e.fd  = 1'b0;
      m_n = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pf = 1'b0;
    end else begin
      d     = int'((m_n / DIV) % DIGITS);
      bnd   = ((m_n % FRAME) == FRAME - 1);
      nib   = m_act[4*d +: 4];
      upper = m_act >> (4 * d);
      e.seg = seg_tab[nib];
      if (i_Blank_Zeros && d > 0 && upper == 16'h0) e.seg = 8'hFF;
      if (m_act_dp[d]) e.seg[7] = 1'b0;
      if ((m_n % (1 << BRIGHT_W)) <= i_Brightness) e.sel = ~(DIGITS'(1) << d);
      else e.sel = '1;
      e.fd = bnd;
      if (bnd && m_pf) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_pf = 1'b0;
      end
      if (i_Load) begin
        m_pend = i_Data; m_pend_dp = i_DP; m_pf = 1'b1;
      end
      m_n++;
    end
    sb_q.push_back(e);
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle.
  always @(negedge i_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("select", 8'(o_Chosen_Segment), 8'(e.sel));
      check("segments", o_SevenSegmentDisplay, e.seg);
      check("frame_done", 8'(o_Frame_Done), 8'(e.fd));
    end
  end

  task automatic step(input logic ld, input logic [15:0] d, input logic [DIGITS-1:0] p,
                      input logic rst);
    @(negedge i_clk);
    i_Load  = ld;
    i_Data  = d;
    i_DP    = p;
    i_reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, i_Data, i_DP, 1'b0);
  endtask

  // Returns with the next step() landing on a frame-boundary edge.
  task automatic to_boundary();
    for (int i = 0; i < 2 * FRAME && ((m_n + 1) % FRAME) != FRAME - 1; i++) idle(1);
  endtask

  initial begin
    logic [15:0] rd;
    int          lows;
    i_reset = 1'b1; i_Load = 1'b0; i_Data = '0; i_DP = '0;
    i_Blank_Zeros = 1'b0; i_Brightness = 2'd3;
    repeat (3) step(1'b0, 16'h0, 4'h0, 1'b1);
    idle(40);

    // Mid-frame load with a decimal point on digit 2.
    step(1'b1, 16'h12AF, 4'b0100, 1'b0);
    idle(40);

    // Leading-zero suppression.
    @(negedge i_clk); i_Blank_Zeros = 1'b1;
    step(1'b1, 16'h0050, 4'b0000, 1'b0);
    idle(40);

    // Minimum brightness: one lit cycle in four.
    @(negedge i_clk); i_Brightness = 2'd0;
    idle(2);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (o_Chosen_Segment != '1) lows++;
    end
    check("duty_min", 8'(lows), 8'd4);
    @(negedge i_clk); i_Brightness = 2'd3;
    idle(20);

    // Load coincident with frame boundary while pending is already set.
    to_boundary();
    idle(3);
    step(1'b1, 16'h3456, 4'b0001, 1'b0);
    to_boundary();
    step(1'b1, 16'h789B, 4'b1000, 1'b0);
    idle(40);

    // Reset pulse mid-frame with pending data.
    step(1'b1, 16'hCDEF, 4'b1111, 1'b0);
    idle(3);
    step(1'b0, i_Data, i_DP, 1'b1);
    idle(40);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) i_Blank_Zeros = ~i_Blank_Zeros;
      if ($urandom_range(0, 15) == 0) i_Brightness = BRIGHT_W'($urandom_range(0, 3));
      rd = 16'($urandom);
      rd = rd >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 7) == 0, rd, DIGITS'($urandom), $urandom_range(0, 199) == 0);
    end
    idle(3);
    @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
